// File: rtl/gf2m16_reduce_pipe.sv
// Two-stage reduction of a 31-bit carry-less product modulo x^16 + POLY.
// Stage 1 folds bits 30..23 and stage 2 folds bits 22..16. Both stages use valid/ready handshakes.
module gf2m16_reduce_pipe #(
  parameter logic [15:0] POLY  = 16'h002B,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [30:0]      in_prod,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      xfer_cnt
);

  // Scan from the top down. A fold can set lower bits that are still inside the
  // scanned range, and those bits are folded later in the same loop.
  function automatic logic [22:0] fold_hi(input logic [30:0] c);
    logic [30:0] t;
    t = c;
    for (int unsigned k = 30; k >= 23; k--) begin
      if (t[k]) begin
        t[k]            = 1'b0;
        t[k-16 +: 16]   = t[k-16 +: 16] ^ POLY;
      end
    end
    return t[22:0];
  endfunction

  function automatic logic [15:0] fold_lo(input logic [22:0] r);
    logic [22:0] t;
    t = r;
    for (int unsigned k = 22; k >= 16; k--) begin
      if (t[k]) begin
        t[k]            = 1'b0;
        t[k-16 +: 16]   = t[k-16 +: 16] ^ POLY;
      end
    end
    return t[15:0];
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [22:0]      s1_data_q,  s1_data_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [15:0]      s2_res_q,   s2_res_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic [15:0]      xfer_q,     xfer_d;

  logic s1_load, s1_move, adv2;

  always_comb begin
    in_ready   = ~rst & (~s1_valid_q | ~s2_valid_q | out_ready);
    s1_load    = in_valid & in_ready;
    s1_move    = s1_valid_q & (~s2_valid_q | out_ready);
    adv2       = s2_valid_q & out_ready;

    s1_valid_d = s1_load | (s1_valid_q & ~s1_move);
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    if (s1_load) begin
      s1_data_d = fold_hi(in_prod);
      s1_tag_d  = in_tag;
    end

    s2_valid_d = s1_move | (s2_valid_q & ~adv2);
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    if (s1_move) begin
      s2_res_d = fold_lo(s1_data_q);
      s2_tag_d = s1_tag_q;
    end

    xfer_d = xfer_q + {15'd0, adv2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      xfer_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
      xfer_q     <= xfer_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_tag   = s2_tag_q;
  assign xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_gf2m16_reduce_pipe.sv
// Self-checking bench for gf2m16_reduce_pipe. The reference model is a queue of
// expected results, each one computed by polynomial long division mod 0x1002B.
module tb_gf2m16_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_prod;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic [3:0]  out_tag;
  logic [15:0] xfer_cnt;

  gf2m16_reduce_pipe #(.POLY(16'h002B), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    int          acc;
  } item_t;

  item_t       exp_q[$];
  logic [15:0] seen_res[$];
  logic [3:0]  seen_tag[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          ecnt = 0;
  int          results = 0;
  logic [15:0] model_cnt = '0;
  bit          acc_flag = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_res;
  logic [3:0]  prev_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, ecnt);
    end
  endtask

  function automatic logic [15:0] ref_mod(input logic [30:0] c);
    logic [31:0] r;
    r = {1'b0, c};
    for (int i = 30; i >= 16; i--)
      if (r[i]) r = r ^ (32'h0001_002B << (i - 16));
    return r[15:0];
  endfunction

  // Inputs are driven just after a falling edge. Outputs are checked 1 ns later.
  // Any handshake that the next rising edge will complete is then recorded.
  task automatic tick();
    item_t it;
    bit    exp_ov;
    #1;
    check("xfer_cnt", 32'(xfer_cnt), 32'(model_cnt));
    exp_ov = (exp_q.size() > 0) && (ecnt > exp_q[0].acc);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(!rst && (exp_q.size() < 2 || out_ready)));
    check("occupancy", 32'(exp_q.size() <= 2), 32'(1));
    if (prev_stall) begin
      check("hold_res", 32'(out_res), 32'(prev_res));
      check("hold_tag", 32'(out_tag), 32'(prev_tag));
    end
    prev_stall = (out_valid === 1'b1) && !out_ready && !rst;
    prev_res   = out_res;
    prev_tag   = out_tag;
    acc_flag   = 0;
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
      results   = 0;
    end else begin
      if (out_valid && out_ready) begin
        seen_res.push_back(out_res);
        seen_tag.push_back(out_tag);
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'(0));
        else begin
          it = exp_q.pop_front();
          check("out_res", 32'(out_res), 32'(it.res));
          check("out_tag", 32'(out_tag), 32'(it.tag));
        end
        model_cnt++;
        results++;
      end
      if (in_valid && in_ready) begin
        it.res = ref_mod(in_prod);
        it.tag = in_tag;
        it.acc = ecnt + 1;
        exp_q.push_back(it);
        acc_flag = 1;
      end
    end
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic send(input logic [30:0] p, input logic [3:0] t);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_tag   = t;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) check("send_timeout", 32'(acc_flag), 32'(1));
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'(0));
  endtask

  logic [30:0] kv_in  [4] = '{31'h0001_0000, 31'h0000_FFFF, 31'h4000_0000, 31'h0};
  logic [15:0] kv_out [4] = '{16'h002B, 16'hFFFF, 16'hC10E, 16'h0000};

  initial begin
    int cnt;
    int sent;
    int n;

    // Test 1: hold reset with in_valid high. Nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_prod = 31'h1234_5678; in_tag = 4'h7; out_ready = 1'b0;
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_res", 32'(out_res), 32'(0));
    check("rst_out_tag", 32'(out_tag), 32'(0));
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("first_accept", 32'(acc_flag), 32'(1));
    drain();

    // Test 2: known vectors streamed back to back.
    seen_res.delete(); seen_tag.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(kv_in[i], 4'(i + 1));
    drain();
    check("kv_count", 32'(seen_res.size()), 32'(4));
    for (int i = 0; i < 4 && i < seen_res.size(); i++) begin
      check("kv_res", 32'(seen_res[i]), 32'(kv_out[i]));
      check("kv_tag", 32'(seen_tag[i]), 32'(i + 1));
    end

    // Test 3: backpressure, then release.
    seen_res.delete(); seen_tag.delete();
    out_ready = 1'b0;
    cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6 && cnt < 6; ) begin
      in_prod = 31'($urandom);
      in_tag  = 4'(5 + i);
      tick();
      if (acc_flag) begin cnt++; i++; end
      if (ecnt > 400) break;
      if (i >= 2 && cnt == 2) break;
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (acc_flag) cnt++;
    end
    check("bp_accepts", 32'(cnt), 32'(2));
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) send(31'($urandom), 4'(5 + i));
    drain();
    check("bp_count", 32'(seen_tag.size()), 32'(6));
    for (int i = 0; i < 6 && i < seen_tag.size(); i++)
      check("bp_order", 32'(seen_tag[i]), 32'(5 + i));

    // Test 5: reset with two items in flight.
    seen_res.delete(); seen_tag.delete();
    out_ready = 1'b0;
    send(31'h7ABC_DEF0, 4'hA);
    send(31'h0123_4567, 4'hB);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'(0));
    out_ready = 1'b1;
    send(31'h5555_AAAA, 4'hC);
    send(31'h2AAA_5555, 4'hD);
    drain();
    cnt = 0;
    foreach (seen_tag[i]) if (seen_tag[i] == 4'hA || seen_tag[i] == 4'hB) cnt++;
    check("flushed_tags", 32'(cnt), 32'(0));
    check("post_flush_count", 32'(seen_tag.size()), 32'(2));

    // Test 4: random traffic. An item is held until it is accepted.
    sent = 0; n = 0;
    in_valid = 1'b0; acc_flag = 0;
    while (sent < 10000 && n < 40000) begin
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(3) != 0);
        in_prod  = ($urandom_range(7) == 0) ? 31'($urandom_range(16'hFFFF)) : 31'($urandom);
        in_tag   = 4'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      tick();
      if (acc_flag) sent++;
      n++;
    end
    check("rand_sent", 32'(sent), 32'(10000));
    drain();
    check("xfer_vs_results", 32'(xfer_cnt), 32'(16'(results)));

    // Test 6: run the transfer counter through its wrap point.
    in_valid = 1'b1; out_ready = 1'b1; n = 0;
    while (model_cnt != 16'hFFFF && n < 70000) begin
      if (acc_flag) begin
        in_prod = 31'($urandom);
        in_tag  = 4'($urandom);
      end
      tick();
      n++;
    end
    check("pre_wrap", 32'(xfer_cnt), 32'(16'hFFFF));
    n = 0;
    while (model_cnt != 16'h0000 && n < 10) begin
      tick();
      n++;
    end
    check("wrap", 32'(xfer_cnt), 32'(16'h0000));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
